ofdm_symbol_reorder: RTL



---
 rtl/ofdm_symbol_reorder_if.sv | 27 ++
 rtl/ofdm_symbol_reorder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ofdm_symbol_reorder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ofdm_symbol_reorder_if
//  Purpose  : Avalon-ST sample stream (data, valid, ready, sop, eop).
//  Revision : 1.0  initial release
// ============================================================================
interface ofdm_symbol_reorder_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  startofpacket;
    logic                  endofpacket;

    modport master (
        output data, valid, startofpacket, endofpacket,
        input  ready
    );

    modport slave (
        input  data, valid, startofpacket, endofpacket,
        output ready
    );
endinterface
`default_nettype wire

// File: rtl/ofdm_symbol_reorder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ofdm_symbol_reorder
//  Purpose  : Ping-pong symbol buffer; replays each symbol in bit-reversed
//             order when OFDM_REORDER_BITREV_EN is defined, natural otherwise.
//  Revision : 1.0  initial release
// ============================================================================
module ofdm_symbol_reorder #(
    parameter int OFDM_SYMBOL_LENGTH = 64,
    parameter int ADDR_WIDTH         = 6
) (
    input  wire logic              clock_clk,
    input  wire logic              reset_reset,
    ofdm_symbol_reorder_if.slave   asi_in0,
    ofdm_symbol_reorder_if.master  aso_out0,
    output logic                   overflow_pulse,
    output logic                   framing_error_pulse
);

    localparam logic [ADDR_WIDTH-1:0] c_last = ADDR_WIDTH'(OFDM_SYMBOL_LENGTH - 1);

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_FILL = 2'd1,
        W_DROP = 2'd2
    } wstate_t;

    typedef enum logic [0:0] {
        R_IDLE   = 1'b0,
        R_STREAM = 1'b1
    } rstate_t;

    wstate_t               r_wstate;
    rstate_t               r_rstate;
    logic [1:0]            r_full;
    logic                  r_wptr;
    logic                  r_rptr;
    logic [ADDR_WIDTH-1:0] r_wcnt;
    logic [ADDR_WIDTH-1:0] r_rcnt;
    logic                  r_rdone;
    logic [31:0]           r_mem [0:2*OFDM_SYMBOL_LENGTH-1];

    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [ADDR_WIDTH-1:0] w_raddr;
    logic                  w_commit;
    logic                  w_free;
    logic                  w_load;

    // Upstream has no backpressure; ready is tied high for completeness.
    assign asi_in0.ready = 1'b1;

`ifdef OFDM_REORDER_BITREV_EN
    for (genvar gi = 0; gi < ADDR_WIDTH; gi++) begin : g_bitrev
        assign w_raddr[gi] = r_rcnt[ADDR_WIDTH-1-gi];
    end
`else
    assign w_raddr = r_rcnt;
`endif

    always_comb begin
        w_we     = 1'b0;
        w_waddr  = r_wcnt;
        w_commit = 1'b0;
        if (asi_in0.valid) begin
            case (r_wstate)
                W_IDLE: begin
                    if (asi_in0.startofpacket && !r_full[r_wptr]) begin
                        w_we    = 1'b1;
                        w_waddr = '0;
                    end
                end
                W_FILL: begin
                    w_we = 1'b1;
                    if (asi_in0.startofpacket) begin
                        w_waddr = '0;
                    end else if (r_wcnt == c_last) begin
                        w_commit = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_free = (r_rstate == R_STREAM) && aso_out0.valid && aso_out0.ready
                    && aso_out0.endofpacket;
    assign w_load = !aso_out0.valid || aso_out0.ready;

    always_ff @(posedge clock_clk) begin
        if (w_we) begin
            r_mem[{r_wptr, w_waddr}] <= asi_in0.data;
        end
    end

    // Commit targets a free bank and release targets a full one, so they never collide.
    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_full <= 2'b00;
        end else begin
            r_full <= (r_full | (w_commit ? (2'b01 << r_wptr) : 2'b00))
                      & ~(w_free ? (2'b01 << r_rptr) : 2'b00);
        end
    end

    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_wstate            <= W_IDLE;
            r_wptr              <= 1'b0;
            r_wcnt              <= '0;
            overflow_pulse      <= 1'b0;
            framing_error_pulse <= 1'b0;
        end else begin
            overflow_pulse      <= 1'b0;
            framing_error_pulse <= 1'b0;
            if (asi_in0.valid) begin
                case (r_wstate)
                    W_IDLE: begin
                        if (asi_in0.startofpacket) begin
                            if (r_full[r_wptr]) begin
                                overflow_pulse <= 1'b1;
                                r_wstate       <= W_DROP;
                            end else begin
                                r_wcnt   <= ADDR_WIDTH'(1);
                                r_wstate <= W_FILL;
                            end
                        end
                    end
                    W_FILL: begin
                        if (asi_in0.startofpacket) begin
                            framing_error_pulse <= 1'b1;
                            r_wcnt              <= ADDR_WIDTH'(1);
                        end else if (r_wcnt == c_last) begin
                            framing_error_pulse <= !asi_in0.endofpacket;
                            r_wptr              <= ~r_wptr;
                            r_wstate            <= W_IDLE;
                        end else if (asi_in0.endofpacket) begin
                            framing_error_pulse <= 1'b1;
                            r_wstate            <= W_IDLE;
                        end else begin
                            r_wcnt <= r_wcnt + ADDR_WIDTH'(1);
                        end
                    end
                    W_DROP: begin
                        if (asi_in0.endofpacket) begin
                            r_wstate <= W_IDLE;
                        end
                    end
                    default: r_wstate <= W_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_rstate               <= R_IDLE;
            r_rptr                 <= 1'b0;
            r_rcnt                 <= '0;
            r_rdone                <= 1'b0;
            aso_out0.valid         <= 1'b0;
            aso_out0.data          <= '0;
            aso_out0.startofpacket <= 1'b0;
            aso_out0.endofpacket   <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (r_full[r_rptr]) begin
                        r_rstate <= R_STREAM;
                        r_rcnt   <= '0;
                        r_rdone  <= 1'b0;
                    end
                end
                R_STREAM: begin
                    if (w_free) begin
                        aso_out0.valid         <= 1'b0;
                        aso_out0.startofpacket <= 1'b0;
                        aso_out0.endofpacket   <= 1'b0;
                        r_rptr                 <= ~r_rptr;
                        r_rstate               <= R_IDLE;
                    end else if (w_load && !r_rdone) begin
                        aso_out0.data          <= r_mem[{r_rptr, w_raddr}];
                        aso_out0.valid         <= 1'b1;
                        aso_out0.startofpacket <= (r_rcnt == '0);
                        aso_out0.endofpacket   <= (r_rcnt == c_last);
                        r_rdone                <= (r_rcnt == c_last);
                        r_rcnt                 <= r_rcnt + ADDR_WIDTH'(1);
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
